// File: rtl/meas_sequencer.sv
// Sequences one frequency measurement: clear counter, open gate window, settle,
// capture the count, then stream {4'b1010, result} out serially MSB first.
module meas_sequencer #(
  parameter int COUNTER_LENGTH = 20,
  parameter int GATE_WIDTH     = 16,
  parameter int SETTLE_CYCLES  = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ena,
  input  logic                      start,
  input  logic                      continuous,
  input  logic [GATE_WIDTH-1:0]     gate_len,
  input  logic [COUNTER_LENGTH-1:0] cycle_count,
  output logic                      ctr_reset,
  output logic                      gate,
  output logic [COUNTER_LENGTH-1:0] result,
  output logic                      result_valid,
  output logic                      serial_out,
  output logic                      busy
);

  localparam int SH_LEN = COUNTER_LENGTH + 4;
  localparam int TW_A   = (GATE_WIDTH > $clog2(SH_LEN + 1)) ? GATE_WIDTH : $clog2(SH_LEN + 1);
  localparam int TW_B   = $clog2(SETTLE_CYCLES + 1);
  localparam int TW     = (TW_A > TW_B) ? TW_A : TW_B;

  localparam logic [TW-1:0] CLEAR_LOAD  = TW'(1);
  localparam logic [TW-1:0] SHIFT_LOAD  = TW'(SH_LEN - 1);
  localparam logic [TW-1:0] SETTLE_LOAD = (SETTLE_CYCLES > 0) ? TW'(SETTLE_CYCLES - 1) : '0;

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_GATE, S_SETTLE, S_CAPTURE, S_SHIFT
  } state_e;

  state_e                    state_q, state_d;
  logic [TW-1:0]             cnt_q, cnt_d;
  logic [GATE_WIDTH-1:0]     gate_len_q, gate_len_d;
  logic [SH_LEN-1:0]         frame_q, frame_d;
  logic [COUNTER_LENGTH-1:0] result_q, result_d;
  logic                      result_valid_q, result_valid_d;
  logic                      ctr_reset_q, ctr_reset_d;
  logic                      gate_q, gate_d;
  logic                      serial_q, serial_d;
  logic                      busy_q, busy_d;

  // cnt_q holds remaining cycles minus one in the timed states.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    gate_len_d     = gate_len_q;
    frame_d        = frame_q;
    result_d       = result_q;
    result_valid_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start && gate_len != '0) begin
          state_d    = S_CLEAR;
          cnt_d      = CLEAR_LOAD;
          gate_len_d = gate_len;
        end
      end
      S_CLEAR: begin
        if (cnt_q == '0) begin
          state_d = S_GATE;
          cnt_d   = TW'(gate_len_q) - TW'(1);
        end else begin
          cnt_d = cnt_q - TW'(1);
        end
      end
      S_GATE: begin
        if (cnt_q == '0) begin
          if (SETTLE_CYCLES == 0) begin
            state_d = S_CAPTURE;
          end else begin
            state_d = S_SETTLE;
            cnt_d   = SETTLE_LOAD;
          end
        end else begin
          cnt_d = cnt_q - TW'(1);
        end
      end
      S_SETTLE: begin
        if (cnt_q == '0) begin
          state_d = S_CAPTURE;
        end else begin
          cnt_d = cnt_q - TW'(1);
        end
      end
      S_CAPTURE: begin
        state_d        = S_SHIFT;
        cnt_d          = SHIFT_LOAD;
        result_d       = cycle_count;
        result_valid_d = 1'b1;
        frame_d        = {4'b1010, cycle_count};
      end
      S_SHIFT: begin
        if (cnt_q == '0) begin
          if (continuous) begin
            state_d = S_CLEAR;
            cnt_d   = CLEAR_LOAD;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d   = cnt_q - TW'(1);
          frame_d = {frame_q[SH_LEN-2:0], 1'b0};
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they register in step with it.
    ctr_reset_d = (state_d == S_CLEAR);
    gate_d      = (state_d == S_GATE);
    busy_d      = (state_d != S_IDLE);
    serial_d    = (state_d == S_SHIFT) && frame_d[SH_LEN-1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      gate_len_q     <= '0;
      frame_q        <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      ctr_reset_q    <= 1'b0;
      gate_q         <= 1'b0;
      serial_q       <= 1'b0;
      busy_q         <= 1'b0;
    end else if (ena) begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      gate_len_q     <= gate_len_d;
      frame_q        <= frame_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      ctr_reset_q    <= ctr_reset_d;
      gate_q         <= gate_d;
      serial_q       <= serial_d;
      busy_q         <= busy_d;
    end
  end

  assign ctr_reset    = ctr_reset_q;
  assign gate         = gate_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign serial_out   = serial_q;
  assign busy         = busy_q;

endmodule
